pixel_stream_packer: RTL and testbench

Parametrised successor to the RGB-to-32-bit stream packer in the imager pipeline. It packs raw or N-channel pixels MSB-first into OUT_WIDTH-bit words, packs 16-bit header metadata, and flushes partial words at frame end. It drives a downstream sink through a small output FIFO with ready/valid backpressure and a sticky overflow flag. It sits between the colour pipeline and the USB/DMA stream writer.

---
 rtl/pixel_stream_packer_pkg.sv | 20 ++
 rtl/stream_out_fifo.sv | 71 +++++++
 rtl/pixel_stream_packer.sv | 184 ++++++++++++++++++
 tb/tb_pixel_stream_packer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_packer_pkg.sv
// Shared stream data-type codes for the imager packing pipeline.
package pixel_stream_packer_pkg;

    localparam int unsigned DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 4'h4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 4'h8;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 4'h8;

    // Header word index that carries image_type instead of the input value.
    localparam int unsigned Image_image_type = 2;

    function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dtype);
        return |(dtype & DTYPE_PIXEL_MASK);
    endfunction

endpackage

// File: rtl/stream_out_fifo.sv
// Output FIFO with a registered head; an entry leaves storage only when the head transfers.
module stream_out_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_wr;
    logic [AW-1:0]    w_rd_inc;

    assign o_full   = (r_cnt == CW'(DEPTH));
    assign o_empty  = (r_cnt == '0);
    assign w_wr     = i_push && (!o_full || i_pop);
    assign w_rd_inc = r_rd + AW'(1);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + AW'(1);
            end
            if (i_pop) begin
                r_rd <= w_rd_inc;
            end
            if (w_wr && !i_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_wr && i_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // Head reloads from storage as it stood before this edge's write.
            if (i_pop) begin
                o_valid <= (r_cnt >= CW'(2));
                if (r_cnt >= CW'(2)) begin
                    o_data <= r_mem[w_rd_inc];
                end
            end else if (!o_valid) begin
                o_valid <= (r_cnt != '0);
                if (r_cnt != '0) begin
                    o_data <= r_mem[r_rd];
                end
            end
        end
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs raw/colour pixels and 16-bit header metadata MSB-first into OUT_WIDTH-bit words.
module pixel_stream_packer
    import pixel_stream_packer_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = 10,
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned OUT_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [15:0]                         image_type,
    input  logic                                dvi,
    input  logic [DTYPE_WIDTH-1:0]              dtypei,
    input  logic [15:0]                         meta_datai,
    input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] pixi,
    input  logic                                ordy,
    output logic                                dvo,
    output logic [DTYPE_WIDTH-1:0]              dtypeo,
    output logic [OUT_WIDTH-1:0]                datao,
    output logic                                overflow,
    output logic                                seq_err
);
    localparam int unsigned CPW   = NUM_CHANNELS * PIXEL_WIDTH;
    localparam int unsigned ACC_W = OUT_WIDTH + CPW;
    localparam int unsigned CW    = $clog2(ACC_W + 1);
    localparam int unsigned SLOTS = OUT_WIDTH / 16;
    localparam int unsigned SW    = $clog2(SLOTS + 1);
    localparam int unsigned EW    = DTYPE_WIDTH + OUT_WIDTH;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]             r_state;
    logic [ACC_W-1:0]       r_acc;
    logic [CW-1:0]          r_cnt;
    logic [15:0]            r_hcnt;
    logic [OUT_WIDTH-1:0]   r_hdr;
    logic [SW-1:0]          r_slot;
    logic                   r_overflow;
    logic                   r_seq_err;

    logic [0:0]             w_state_nxt;
    logic [ACC_W-1:0]       w_acc_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [CW-1:0]          w_sum;
    logic [15:0]            w_hcnt_nxt;
    logic [15:0]            w_hval;
    logic [OUT_WIDTH+15:0]  w_hcat;
    logic [OUT_WIDTH-1:0]   w_hdr_nxt;
    logic [SW-1:0]          w_slot_nxt;
    logic                   w_push;
    logic [DTYPE_WIDTH-1:0] w_push_type;
    logic [OUT_WIDTH-1:0]   w_push_data;
    logic                   w_seq_set;
    logic                   w_clr;
    logic                   w_full;
    logic                   w_fifo_empty;
    logic                   w_pop;
    logic                   w_drop;
    logic [EW-1:0]          w_head;

    always_comb begin
        w_state_nxt = ST_RUN;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sum       = '0;
        w_hcnt_nxt  = r_hcnt;
        w_hval      = '0;
        w_hcat      = '0;
        w_hdr_nxt   = r_hdr;
        w_slot_nxt  = r_slot;
        w_push      = 1'b0;
        w_push_type = '0;
        w_push_data = '0;
        w_seq_set   = 1'b0;
        w_clr       = 1'b0;
        if (r_state == ST_PEND) begin
            w_push      = 1'b1;
            w_push_type = DTYPE_FRAME_END;
            w_seq_set   = dvi;
        end else if (dvi) begin
            if (is_pixel(dtypei)) begin
                if (image_type == '0) begin
                    w_acc_nxt = (r_acc << PIXEL_WIDTH) | ACC_W'(meta_datai[PIXEL_WIDTH-1:0]);
                    w_sum     = r_cnt + CW'(PIXEL_WIDTH);
                end else begin
                    w_acc_nxt = (r_acc << CPW) | ACC_W'(pixi);
                    w_sum     = r_cnt + CW'(CPW);
                end
                if (w_sum >= CW'(OUT_WIDTH)) begin
                    w_push      = 1'b1;
                    w_push_type = dtypei;
                    w_push_data = OUT_WIDTH'(w_acc_nxt >> (w_sum - CW'(OUT_WIDTH)));
                    w_cnt_nxt   = w_sum - CW'(OUT_WIDTH);
                end else begin
                    w_cnt_nxt   = w_sum;
                end
            end else if (dtypei == DTYPE_FRAME_START || dtypei == DTYPE_HEADER_START) begin
                w_cnt_nxt   = '0;
                w_hcnt_nxt  = '0;
                w_slot_nxt  = '0;
                w_push      = 1'b1;
                w_push_type = dtypei;
                w_clr       = (dtypei == DTYPE_FRAME_START);
            end else if (dtypei == DTYPE_HEADER) begin
                w_hval     = (r_hcnt == 16'(Image_image_type)) ? image_type : meta_datai;
                w_hcat     = {r_hdr, w_hval};
                w_hdr_nxt  = w_hcat[OUT_WIDTH-1:0];
                w_hcnt_nxt = r_hcnt + 16'd1;
                if (r_slot == SW'(SLOTS - 1)) begin
                    w_push      = 1'b1;
                    w_push_type = dtypei;
                    w_push_data = w_hdr_nxt;
                    w_slot_nxt  = '0;
                end else begin
                    w_slot_nxt  = r_slot + SW'(1);
                end
            end else if (dtypei == DTYPE_FRAME_END) begin
                w_seq_set  = (r_slot != '0);
                w_slot_nxt = '0;
                w_push     = 1'b1;
                if (r_cnt != '0) begin
                    w_push_type = DTYPE_PIXEL;
                    w_push_data = OUT_WIDTH'(r_acc << (CW'(OUT_WIDTH) - r_cnt));
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_PEND;
                end else begin
                    w_push_type = dtypei;
                end
            end else begin
                w_push      = 1'b1;
                w_push_type = dtypei;
            end
        end
    end

    assign w_pop  = dvo && ordy && !w_fifo_empty;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_hdr      <= '0;
            r_slot     <= '0;
            r_overflow <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_hdr      <= w_hdr_nxt;
            r_slot     <= w_slot_nxt;
            // A drop in the same cycle as FRAME_START still registers.
            r_overflow <= (r_overflow && !w_clr) || w_drop;
            r_seq_err  <= (r_seq_err && !w_clr) || w_seq_set;
        end
    end

    stream_out_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_data  ({w_push_type, w_push_data}),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_empty (w_fifo_empty),
        .o_valid (dvo),
        .o_data  (w_head)
    );

    assign dtypeo   = w_head[EW-1:OUT_WIDTH];
    assign datao    = w_head[OUT_WIDTH-1:0];
    assign overflow = r_overflow;
    assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer against a bit-queue reference model.
module tb_pixel_stream_packer;
    import pixel_stream_packer_pkg::*;

    localparam int unsigned PW  = 10;
    localparam int unsigned NC  = 3;
    localparam int unsigned OW  = 32;
    localparam int unsigned FD  = 4;
    localparam int unsigned CPW = PW * NC;
    localparam int unsigned DW  = DTYPE_WIDTH;

    typedef logic [DW+OW-1:0] word_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [15:0]      image_type = '0;
    logic             dvi = 1'b0;
    logic [DW-1:0]    dtypei = '0;
    logic [15:0]      meta_datai = '0;
    logic [CPW-1:0]   pixi = '0;
    logic             ordy = 1'b1;
    logic             dvo;
    logic [DW-1:0]    dtypeo;
    logic [OW-1:0]    datao;
    logic             overflow;
    logic             seq_err;

    pixel_stream_packer #(
        .PIXEL_WIDTH  (PW),
        .NUM_CHANNELS (NC),
        .OUT_WIDTH    (OW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .image_type (image_type),
        .dvi        (dvi),
        .dtypei     (dtypei),
        .meta_datai (meta_datai),
        .pixi       (pixi),
        .ordy       (ordy),
        .dvo        (dvo),
        .dtypeo     (dtypeo),
        .datao      (datao),
        .overflow   (overflow),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Reference model state
    word_t       exp_q[$];
    bit          bq[$];
    logic [15:0] hq[$];
    int          m_hcnt = 0;
    bit          m_ovf = 0;
    bit          m_seq = 0;
    int          m_pend_cyc = -1;
    int          xq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && dvo && ordy) begin
            xq.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", {dtypeo, datao}, cyc);
            end else begin
                chk("out_word", {dtypeo, datao}, exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        exp_q.delete(); bq.delete(); hq.delete();
        m_hcnt = 0; m_ovf = 0; m_seq = 0; m_pend_cyc = -1;
    endtask

    task automatic model(input logic [DW-1:0] dt, input logic [15:0] meta,
                         input logic [CPW-1:0] pix, input logic [15:0] itype, input int ncyc);
        logic [OW-1:0] d;
        if (ncyc == m_pend_cyc) begin
            m_seq = 1;
            return;
        end
        if ((dt & DTYPE_PIXEL_MASK) != '0) begin
            if (itype == 16'h0) for (int i = PW - 1; i >= 0; i--) bq.push_back(meta[i]);
            else                for (int i = CPW - 1; i >= 0; i--) bq.push_back(pix[i]);
            if (bq.size() >= OW) begin
                for (int i = OW - 1; i >= 0; i--) d[i] = bq.pop_front();
                exp_q.push_back({dt, d});
            end
        end else if (dt == DTYPE_FRAME_START || dt == DTYPE_HEADER_START) begin
            bq.delete(); hq.delete(); m_hcnt = 0;
            if (dt == DTYPE_FRAME_START) begin m_ovf = 0; m_seq = 0; end
            exp_q.push_back({dt, {OW{1'b0}}});
        end else if (dt == DTYPE_HEADER) begin
            hq.push_back((m_hcnt == Image_image_type) ? itype : meta);
            m_hcnt++;
            if (hq.size() == OW / 16) begin
                d = '0;
                for (int i = 0; i < OW / 16; i++) d = (d << 16) | OW'(hq[i]);
                exp_q.push_back({dt, d});
                hq.delete();
            end
        end else if (dt == DTYPE_FRAME_END) begin
            if (hq.size() != 0) begin m_seq = 1; hq.delete(); end
            if (bq.size() > 0) begin
                d = '0;
                for (int i = 0; i < bq.size(); i++) d[OW-1-i] = bq[i];
                exp_q.push_back({DTYPE_PIXEL, d});
                exp_q.push_back({dt, {OW{1'b0}}});
                bq.delete();
                m_pend_cyc = ncyc + 1;
            end else begin
                exp_q.push_back({dt, {OW{1'b0}}});
            end
        end else begin
            exp_q.push_back({dt, {OW{1'b0}}});
        end
    endtask

    task automatic ev(input logic [DW-1:0] dt, input logic [15:0] meta, input logic [CPW-1:0] pix);
        dvi = 1'b1; dtypei = dt; meta_datai = meta; pixi = pix;
        model(dt, meta, pix, image_type, cyc);
        @(posedge clk); #1;
        dvi = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic settle();
        int n = 0;
        ordy = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        chk("drain", 64'(exp_q.size()), 64'd0);
        idle(3);
        chk("no_extra_word", 64'(dvo), 64'd0);
        chk("overflow_flag", 64'(overflow), 64'(m_ovf));
        chk("seq_err_flag", 64'(seq_err), 64'(m_seq));
    endtask

    task automatic rand_event();
        int r = $urandom_range(0, 99);
        logic [15:0] m = 16'($urandom);
        logic [CPW-1:0] p = CPW'({$urandom, $urandom});
        if (r < 55)      ev(($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(1, 7)) : DTYPE_PIXEL, m, p);
        else if (r < 70) ev(DTYPE_HEADER, m, p);
        else if (r < 75) ev(DTYPE_HEADER_START, m, p);
        else if (r < 80) begin
            image_type = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
            ev(DTYPE_FRAME_START, m, p);
        end
        else if (r < 88) ev(DTYPE_FRAME_END, m, p);
        else             ev(4'($urandom_range(5, 8) % 8), m, p);
    endtask

    initial begin
        int c0;
        int n;
        // Reset state
        idle(2);
        chk("rst_dvo", 64'(dvo), 64'd0);
        chk("rst_dtypeo", 64'(dtypeo), 64'd0);
        chk("rst_datao", 64'(datao), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
        reset = 1'b0;
        idle(2);

        // Colour frame, 16 pixels, back-to-back output
        image_type = 16'h0001;
        ev(DTYPE_FRAME_START, '0, '0);
        settle();
        xq.delete();
        c0 = cyc;
        for (int i = 0; i < 16; i++) ev(DTYPE_PIXEL, '0, CPW'({$urandom, $urandom}));
        settle();
        chk("colour_words", 64'(xq.size()), 64'd15);
        if (xq.size() == 15) begin
            chk("first_word_cycle", 64'(xq[0]), 64'(c0 + 3));
            chk("last_word_cycle", 64'(xq[14]), 64'(c0 + 17));
        end

        // Raw samples with residual flush
        image_type = 16'h0000;
        ev(DTYPE_FRAME_START, '0, '0);
        for (int i = 0; i < 5; i++) ev(DTYPE_PIXEL, 16'h03FF, '0);
        ev(DTYPE_FRAME_END, '0, '0);
        settle();

        // Header with image_type substitution
        image_type = 16'h00AB;
        ev(DTYPE_FRAME_START, '0, '0);
        ev(DTYPE_HEADER_START, '0, '0);
        ev(DTYPE_HEADER, 16'h1111, '0);
        ev(DTYPE_HEADER, 16'h2222, '0);
        ev(DTYPE_HEADER, 16'h3333, '0);
        ev(DTYPE_HEADER, 16'h4444, '0);
        settle();

        // Overflow with ordy low
        ordy = 1'b0;
        ev(4'h5, '0, '0); ev(4'h6, '0, '0); ev(4'h7, '0, '0);
        ev(4'h0, '0, '0); ev(4'h5, '0, '0); ev(4'h6, '0, '0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        m_ovf = 1;
        idle(2);
        chk("overflow_set", 64'(overflow), 64'd1);
        chk("full_dvo_held", 64'(dvo), 64'd1);
        settle();
        ev(DTYPE_FRAME_START, '0, '0);
        settle();

        // Pixel during the flush cycle
        image_type = 16'h0001;
        ev(DTYPE_PIXEL, '0, CPW'({$urandom, $urandom}));
        ev(DTYPE_FRAME_END, '0, '0);
        ev(DTYPE_PIXEL, '0, CPW'({$urandom, $urandom}));
        settle();
        chk("seq_err_set", 64'(seq_err), 64'd1);
        ev(DTYPE_FRAME_START, '0, '0);
        settle();

        // Random traffic, ordy high
        for (int i = 0; i < 300; i++) begin
            rand_event();
            if ($urandom_range(0, 3) == 0) idle(1);
            if (i % 25 == 24) settle();
        end
        settle();

        // Random traffic, random ordy, occupancy held below FIFO depth
        for (int i = 0; i < 150; i++) begin
            n = 0;
            while (exp_q.size() > 1 && n < 200) begin
                ordy = 1'($urandom_range(0, 1));
                @(posedge clk); #1; n++;
            end
            if (n >= 200) chk("room_timeout", 64'(exp_q.size()), 64'd1);
            ordy = 1'($urandom_range(0, 1));
            rand_event();
            if (i % 25 == 24) settle();
        end
        settle();

        // Reset while words are queued
        ordy = 1'b0;
        ev(4'h5, '0, '0); ev(4'h6, '0, '0); ev(4'h7, '0, '0);
        n = 0;
        while (!dvo && n < 20) begin @(posedge clk); #1; n++; end
        chk("dvo_before_reset", 64'(dvo), 64'd1);
        #2 reset = 1'b1;
        #1 chk("async_dvo_drop", 64'(dvo), 64'd0);
        model_reset();
        idle(2);
        reset = 1'b0;
        ordy = 1'b1;
        idle(5);
        chk("no_stale_word", 64'(dvo), 64'd0);
        ev(DTYPE_FRAME_START, '0, '0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
